// File: rtl/alu_mdu_pipe.sv
// EX-stage ALU with valid/ready handshake plus an iterative multu/divu unit writing HI/LO.
// Latency: ALU/branch/jump/mfhi/mflo results 1 cycle; multu/divu occupy XLEN+1 cycles, no result beat.
// Backpressure: one-deep output register; in_ready drops while MDU active or result held unconsumed.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake;
//   opcode, funct, shamt, src, targ, imm, pc request fields;
//   out_valid/out_ready result handshake; result, br_taken, illegal result fields;
//   busy (MDU iterating); ovf (signed add/sub/addi overflow, only with ALU_OVF_EN).
// Build option: define ALU_OVF_EN to add the ovf output port.
module alu_mdu_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [SHW-1:0]  shamt,
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] targ,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            illegal,
    output logic            busy
`ifdef ALU_OVF_EN
    ,
    output logic            ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] w_hi;      // mult: running upper product / div: partial remainder
    logic [XLEN-1:0] w_lo;      // mult: multiplier shifting out / div: dividend in, quotient out
    logic [XLEN-1:0] op_b;      // mult: multiplicand / div: divisor
    logic            md_div;
    logic [SHW-1:0]  cnt;

    logic            accept;
    logic            start_mul;
    logic            start_div;
    logic [XLEN-1:0] alu_res;
    logic            alu_br;
    logic            alu_ill;
    logic [XLEN-1:0] add_res;
    logic [XLEN-1:0] sub_res;
    logic [XLEN-1:0] addi_res;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_sub;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;
`ifdef ALU_OVF_EN
    logic            alu_ovf;
`endif

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == S_ITER);

    assign add_res  = src + targ;
    assign sub_res  = src - targ;
    assign addi_res = src + imm;

    // Instruction decode and single-cycle datapath
    always_comb begin
        alu_res   = '0;
        alu_br    = 1'b0;
        alu_ill   = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
`ifdef ALU_OVF_EN
        alu_ovf   = 1'b0;
`endif
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin
                        alu_res = add_res;
`ifdef ALU_OVF_EN
                        alu_ovf = (src[XLEN-1] == targ[XLEN-1]) && (add_res[XLEN-1] != src[XLEN-1]);
`endif
                    end
                    6'b100010: begin
                        alu_res = sub_res;
`ifdef ALU_OVF_EN
                        alu_ovf = (src[XLEN-1] != targ[XLEN-1]) && (sub_res[XLEN-1] != src[XLEN-1]);
`endif
                    end
                    6'b100100: alu_res = src & targ;
                    6'b100101: alu_res = src | targ;
                    6'b100110: alu_res = src ^ targ;
                    6'b101010: alu_res = {{(XLEN-1){1'b0}}, ($signed(src) < $signed(targ))};
                    6'b101011: alu_res = {{(XLEN-1){1'b0}}, (src < targ)};
                    6'b000000: alu_res = targ << shamt;
                    6'b000010: alu_res = targ >> shamt;
                    6'b000011: alu_res = $signed(targ) >>> shamt;
                    6'b010000: alu_res = hi;
                    6'b010010: alu_res = lo;
                    6'b011001: start_mul = 1'b1;
                    6'b011011: start_div = 1'b1;
                    default:   alu_ill = 1'b1;
                endcase
            end
            6'b001000: begin
                alu_res = addi_res;
`ifdef ALU_OVF_EN
                alu_ovf = (src[XLEN-1] == imm[XLEN-1]) && (addi_res[XLEN-1] != src[XLEN-1]);
`endif
            end
            6'b100011: alu_res = addi_res;
            6'b101011: alu_res = addi_res;
            6'b001100: alu_res = src & imm;
            6'b000010: alu_res = imm << 2;
            6'b000100: begin
                alu_res = pc + (imm << 2);
                alu_br  = (src == targ);
            end
            6'b000101: begin
                alu_res = pc + (imm << 2);
                alu_br  = (src != targ);
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // One MDU iteration: shift-add multiply (product shifts right through w_hi:w_lo)
    // or restoring divide (remainder/quotient shift left). A zero divisor always
    // "succeeds", which naturally yields quotient all-ones and remainder = dividend.
    always_comb begin
        mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, op_b} : {(XLEN+1){1'b0}});
        div_sh  = {w_hi, w_lo[XLEN-1]};
        div_sub = div_sh - {1'b0, op_b};
        step_hi = mul_sum[XLEN:1];
        step_lo = {mul_sum[0], w_lo[XLEN-1:1]};
        if (md_div) begin
            if (!div_sub[XLEN]) begin
                step_hi = div_sub[XLEN-1:0];
                step_lo = {w_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_sh[XLEN-1:0];
                step_lo = {w_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && (start_mul || start_div)) state_nxt = S_ITER;
            S_ITER: if (cnt == SHW'(XLEN-1)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            hi     <= '0;
            lo     <= '0;
            w_hi   <= '0;
            w_lo   <= '0;
            op_b   <= '0;
            md_div <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept && (start_mul || start_div)) begin
                        w_hi   <= '0;
                        w_lo   <= start_div ? src : targ;
                        op_b   <= start_div ? targ : src;
                        md_div <= start_div;
                        cnt    <= '0;
                    end
                end
                S_ITER: begin
                    w_hi <= step_hi;
                    w_lo <= step_lo;
                    cnt  <= cnt + 1'b1;
                end
                S_DONE: begin
                    hi <= w_hi;
                    lo <= w_lo;
                end
                default: ;
            endcase
        end
    end

    // Result register: loads on any non-MDU accept, otherwise holds until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            br_taken  <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (accept && !(start_mul || start_div)) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            br_taken  <= alu_br;
            illegal   <= alu_ill;
`ifdef ALU_OVF_EN
            ovf       <= alu_ovf;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mdu_pipe.sv
module tb_alu_mdu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src;
    logic [31:0] targ;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        br_taken;
    logic        illegal;
    logic        busy;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [5:0]  a_fn [10];
    logic [4:0]  a_sh [10];
    logic [31:0] a_s  [10];
    logic [31:0] a_t  [10];
    logic [31:0] a_e  [10];
    logic        a_o  [10];

    logic [5:0]  i_op [5];
    logic [31:0] i_s  [5];
    logic [31:0] i_i  [5];
    logic [31:0] i_e  [5];

    alu_mdu_pipe #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .shamt     (shamt),
        .src       (src),
        .targ      (targ),
        .imm       (imm),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .br_taken  (br_taken),
        .illegal   (illegal),
        .busy      (busy)
`ifdef ALU_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Present one request and return #1 after the edge that accepted it.
    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] s, input logic [31:0] t, input logic [31:0] i,
                        input logic [31:0] p);
        int n;
        @(negedge clk);
        opcode = op; funct = fn; shamt = sh; src = s; targ = t; imm = i; pc = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct = '0; shamt = '0; src = '0; targ = '0; imm = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, result, br_taken, illegal, busy} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%0b res=%h br=%0b ill=%0b busy=%0b, required all 0",
                     out_valid, result, br_taken, illegal, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        a_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        a_sh = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd4};
        a_s  = '{32'h7FFFFFFF, 32'h80000000, 32'hF0F0F0F0, 32'h0F0F0000, 32'hAAAA5555,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
        a_t  = '{32'h1, 32'h1, 32'hFF00FF00, 32'h000000F0, 32'hFFFF0000,
                 32'h1, 32'h1, 32'h1, 32'h80000000, 32'h80000000};
        a_e  = '{32'h80000000, 32'h7FFFFFFF, 32'hF000F000, 32'h0F0F00F0, 32'h55555555,
                 32'h1, 32'h0, 32'h80000000, 32'h08000000, 32'hF8000000};
        a_o  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            send(6'h00, a_fn[k], a_sh[k], a_s[k], a_t[k], 32'h0, 32'h0);
            total++;
            if (result !== a_e[k] || out_valid !== 1'b1 || illegal !== 1'b0) begin
                bad++;
                $display("FAIL alu_funct_%h: res=%h ov=%0b ill=%0b, required res=%h ov=1 ill=0",
                         a_fn[k], result, out_valid, illegal, a_e[k]);
            end
`ifdef ALU_OVF_EN
            total++;
            if (ovf !== a_o[k]) begin
                bad++;
                $display("FAIL ovf_funct_%h: ovf=%0b, required %0b", a_fn[k], ovf, a_o[k]);
            end
`endif
        end
    endtask

    task automatic test_itype;
        i_op = '{6'h08, 6'h23, 6'h2B, 6'h0C, 6'h02};
        i_s  = '{32'h10, 32'h1000, 32'h2000, 32'h12345678, 32'hDEADBEEF};
        i_i  = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h0000FFFF, 32'h00000100};
        i_e  = '{32'h0000000F, 32'h1008, 32'h1FFC, 32'h00005678, 32'h00000400};
        for (int k = 0; k < 5; k++) begin
            send(i_op[k], 6'h3F, 5'd0, i_s[k], 32'h0, i_i[k], 32'h0);
            total++;
            if (result !== i_e[k] || illegal !== 1'b0 || br_taken !== 1'b0) begin
                bad++;
                $display("FAIL itype_op_%h: res=%h ill=%0b br=%0b, required res=%h ill=0 br=0",
                         i_op[k], result, illegal, br_taken, i_e[k]);
            end
        end
    endtask

    task automatic test_branch;
        send(6'h04, 6'h0, 5'd0, 32'h5, 32'h5, 32'h3, 32'h100);
        total++;
        if (result !== 32'h10C || br_taken !== 1'b1) begin
            bad++;
            $display("FAIL beq_equal: res=%h br=%0b, required res=0000010c br=1", result, br_taken);
        end
        send(6'h05, 6'h0, 5'd0, 32'h5, 32'h5, 32'h3, 32'h100);
        total++;
        if (result !== 32'h10C || br_taken !== 1'b0) begin
            bad++;
            $display("FAIL bne_equal: res=%h br=%0b, required res=0000010c br=0", result, br_taken);
        end
        send(6'h04, 6'h0, 5'd0, 32'h5, 32'h6, 32'hFFFFFFFF, 32'h100);
        total++;
        if (result !== 32'h0FC || br_taken !== 1'b0) begin
            bad++;
            $display("FAIL beq_differ_negimm: res=%h br=%0b, required res=000000fc br=0", result, br_taken);
        end
        send(6'h05, 6'h0, 5'd0, 32'h5, 32'h6, 32'h0, 32'h200);
        total++;
        if (result !== 32'h200 || br_taken !== 1'b1) begin
            bad++;
            $display("FAIL bne_differ: res=%h br=%0b, required res=00000200 br=1", result, br_taken);
        end
    endtask

    task automatic test_illegal;
        send(6'h3F, 6'h0, 5'd0, 32'h1234, 32'h1, 32'h1, 32'h0);
        total++;
        if (result !== 32'h0 || illegal !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL illegal_opcode: res=%h ill=%0b ov=%0b, required 0/1/1", result, illegal, out_valid);
        end
        send(6'h00, 6'h3F, 5'd0, 32'h1234, 32'h1, 32'h0, 32'h0);
        total++;
        if (result !== 32'h0 || illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_funct: res=%h ill=%0b, required 0/1", result, illegal);
        end
        send(6'h00, 6'h25, 5'd0, 32'h1, 32'h2, 32'h0, 32'h0);
        total++;
        if (result !== 32'h3 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clears: res=%h ill=%0b, required 3/0", result, illegal);
        end
    endtask

    task automatic test_mdu;
        int n;
        send(6'h00, 6'h19, 5'd0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL multu_start: busy=%0b rdy=%0b ov=%0b, required 1/0/0", busy, in_ready, out_valid);
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL multu_busy_cycles: got %0d, required 32", n);
        end
        send(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL multu_lo: got %h, required fffffffe", result);
        end
        send(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'h1) begin
            bad++;
            $display("FAIL multu_hi: got %h, required 00000001", result);
        end
        send(6'h00, 6'h1B, 5'd0, 32'h7, 32'h0, 32'h0, 32'h0);
        send(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL divu0_lo: got %h, required ffffffff", result);
        end
        send(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'h7) begin
            bad++;
            $display("FAIL divu0_hi: got %h, required 00000007", result);
        end
        send(6'h00, 6'h1B, 5'd0, 32'd100, 32'd7, 32'h0, 32'h0);
        send(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'd14) begin
            bad++;
            $display("FAIL divu_lo: got %0d, required 14", result);
        end
        send(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'd2) begin
            bad++;
            $display("FAIL divu_hi: got %0d, required 2", result);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk);
        #1;
        @(negedge clk);
        out_ready = 1'b0;
        opcode = 6'h00; funct = 6'h26; shamt = 5'd0; src = 32'h0000FFFF; targ = 32'h00FF00FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Next request waits behind the unconsumed xor result
        funct = 6'h20; src = 32'h1; targ = 32'h2;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (result !== 32'h00FFFF00 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_%0d: res=%h ov=%0b rdy=%0b, required 00ffff00/1/0",
                         k, result, out_valid, in_ready);
            end
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (result !== 32'h3 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: res=%h ov=%0b, required 00000003/1", result, out_valid);
        end
    endtask

    task automatic test_reset_mid_div;
        send(6'h00, 6'h1B, 5'd0, 32'd100, 32'd7, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL middiv_busy: busy=%0b, required 1", busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, result, illegal, br_taken} !== 36'd0) begin
            bad++;
            $display("FAIL middiv_reset: busy=%0b ov=%0b res=%h, required all 0", busy, out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL middiv_lo: got %h, required 0", result);
        end
        send(6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL middiv_hi: got %h, required 0", result);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_itype;
        test_branch;
        test_illegal;
        test_mdu;
        test_back_to_back;
        test_reset_mid_div;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
